// File: rtl/mxu_sequencer_pkg.sv
// Shared types and helpers for the MXU job sequencer: state encoding,
// precision field width and the skew/core/deskew pipeline depth.
package mxu_sequencer_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    // Input skew, core and output deskew stages all advance together.
    function automatic int pipe_lat(input int m, input int k, input int core_lat);
        return (k - 1) + core_lat + (m - 1);
    endfunction

endpackage

// File: rtl/mxu_sequencer_valid_delay_line.sv
// Valid-bit shift register that mirrors the MXU pipeline occupancy; it moves
// only when the array advances, so a frozen array keeps its valid bits.
module valid_delay_line #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] line_q;
    logic [DEPTH-1:0] line_d;

    // Next occupancy: clear wins over shift, otherwise hold.
    always_comb begin
        line_d = line_q;
        if (clear) begin
            line_d = {DEPTH{1'b0}};
        end else if (shift) begin
            line_d = (line_q << 1) | DEPTH'(din);
        end else begin
            line_d = line_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= {DEPTH{1'b0}};
        end else begin
            line_q <= line_d;
        end
    end

    assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/mxu_sequencer.sv
// Control FSM for one matrix-multiply job: accepts a job, streams input
// vectors into the wrapper and delivers results under ready/valid backpressure.
module mxu_sequencer
    import mxu_sequencer_pkg::*;
#(
    parameter int M        = 3,
    parameter int K        = 3,
    parameter int CORE_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    input  logic [CNT_W-1:0]                  cfg_len,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] cfg_data_type,
    input  logic [1:0]                        cfg_fp_unit,
    output logic                              busy,
    output logic                              done,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              feed_zero,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LOG_ALLOWED_PRECISIONS-1:0] mxu_data_type,
    output logic                              mxu_enable,
    output logic                              mxu_enable_in_ff,
    output logic                              mxu_enable_chain,
    output logic                              mxu_enable_out_ff,
    output logic [1:0]                        mxu_enable_fp_unit
);

    localparam int              PIPE_LAT = pipe_lat(M, K, CORE_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    seq_state_e                        state_q, state_d;
    logic [CNT_W-1:0]                  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]                  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]                  len_q, len_d;
    logic [LOG_ALLOWED_PRECISIONS-1:0] dtype_q, dtype_d;
    logic [1:0]                        fp_q, fp_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    logic out_valid_s;
    logic stall_s;
    logic in_ready_s;
    logic in_fire_s;
    logic out_fire_s;
    logic bubble_s;
    logic advance_s;
    logic abort_s;
    logic last_in_s;
    logic last_out_s;

    // Handshake and pipeline-advance decode from registered state.
    always_comb begin
        stall_s    = out_valid_s & ~out_ready;
        in_ready_s = (state_q == ST_STREAM) & ~stall_s;
        in_fire_s  = in_valid & in_ready_s;
        out_fire_s = out_valid_s & out_ready;
        // Push zeros through to drain results while no real input is offered.
        bubble_s   = (state_q == ST_DRAIN) |
                     ((state_q == ST_STREAM) & ~in_valid & out_valid_s);
        advance_s  = ~stall_s & (in_fire_s | bubble_s);
        abort_s    = abort & (state_q != ST_IDLE);
        last_in_s  = (in_cnt_q == (len_q - CNT_ONE));
        last_out_s = (out_cnt_q == (len_q - CNT_ONE));
    end

    // Next-state, counter and job-config logic; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        len_d     = len_q;
        dtype_d   = dtype_q;
        fp_d      = fp_q;
        if (abort_s) begin
            state_d   = ST_IDLE;
            in_cnt_d  = CNT_ZERO;
            out_cnt_d = CNT_ZERO;
        end else begin
            in_cnt_d  = in_fire_s  ? (in_cnt_q + CNT_ONE)  : in_cnt_q;
            out_cnt_d = out_fire_s ? (out_cnt_q + CNT_ONE) : out_cnt_q;
            case (state_q)
                ST_IDLE: begin
                    in_cnt_d  = CNT_ZERO;
                    out_cnt_d = CNT_ZERO;
                    if (start) begin
                        len_d   = cfg_len;
                        dtype_d = cfg_data_type;
                        fp_d    = cfg_fp_unit;
                        state_d = (cfg_len == CNT_ZERO) ? ST_DONE : ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (in_fire_s && last_in_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire_s && last_out_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= CNT_ZERO;
            out_cnt_q <= CNT_ZERO;
            len_q     <= CNT_ZERO;
            dtype_q   <= {LOG_ALLOWED_PRECISIONS{1'b0}};
            fp_q      <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            len_q     <= len_d;
            dtype_q   <= dtype_d;
            fp_q      <= fp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_line (
        .clk   (clk),
        .reset (reset),
        .clear (abort_s),
        .shift (advance_s),
        .din   (in_fire_s),
        .dout  (out_valid_s)
    );

    assign busy               = busy_q;
    assign done               = done_q;
    assign in_ready           = in_ready_s;
    assign out_valid          = out_valid_s;
    assign feed_zero          = advance_s & ~in_fire_s;
    assign mxu_enable         = advance_s;
    assign mxu_enable_in_ff   = advance_s;
    assign mxu_enable_chain   = advance_s;
    assign mxu_enable_out_ff  = advance_s;
    assign mxu_data_type      = dtype_q;
    assign mxu_enable_fp_unit = fp_q;

endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer (M=K=3, CORE_LAT=1, so PIPE_LAT=5); each job
// is a table of per-cycle input masks and hand-derived expected output masks.
module tb_mxu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] cfg_len;
    logic [1:0]  cfg_data_type;
    logic [1:0]  cfg_fp_unit;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic        feed_zero;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  mxu_data_type;
    logic        mxu_enable;
    logic        mxu_enable_in_ff;
    logic        mxu_enable_chain;
    logic        mxu_enable_out_ff;
    logic [1:0]  mxu_enable_fp_unit;

    int n_pass;
    int n_total;

    mxu_sequencer #(
        .M        (3),
        .K        (3),
        .CORE_LAT (1),
        .CNT_W    (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .cfg_len            (cfg_len),
        .cfg_data_type      (cfg_data_type),
        .cfg_fp_unit        (cfg_fp_unit),
        .busy               (busy),
        .done               (done),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .feed_zero          (feed_zero),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .mxu_data_type      (mxu_data_type),
        .mxu_enable         (mxu_enable),
        .mxu_enable_in_ff   (mxu_enable_in_ff),
        .mxu_enable_chain   (mxu_enable_chain),
        .mxu_enable_out_ff  (mxu_enable_out_ff),
        .mxu_enable_fp_unit (mxu_enable_fp_unit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // One job: start at cycle 0, inputs from masks, outputs checked every cycle.
    task automatic run_job(input logic [15:0] len, input logic [1:0] dt, input logic [1:0] fp,
                           input int ncyc, input logic hold_start,
                           input logic [31:0] iv_m, input logic [31:0] or_m,
                           input logic [31:0] ab_m, input logic [31:0] rst_m,
                           input logic [31:0] e_busy, input logic [31:0] e_done,
                           input logic [31:0] e_ir, input logic [31:0] e_ov,
                           input logic [31:0] e_en, input logic [31:0] e_fz,
                           input int e_nin, input int e_nout);
        int   nin;
        int   nout;
        logic rst_seen;
        nin      = 0;
        nout     = 0;
        rst_seen = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            start         = (c == 0) || hold_start;
            cfg_len       = len;
            cfg_data_type = (c == 0) ? dt : ~dt;
            cfg_fp_unit   = (c == 0) ? fp : ~fp;
            in_valid      = iv_m[c];
            out_ready     = or_m[c];
            abort         = ab_m[c];
            reset         = rst_m[c];
            @(negedge clk);
            check("busy", c, {31'd0, busy}, {31'd0, e_busy[c]});
            check("done", c, {31'd0, done}, {31'd0, e_done[c]});
            check("in_ready", c, {31'd0, in_ready}, {31'd0, e_ir[c]});
            check("out_valid", c, {31'd0, out_valid}, {31'd0, e_ov[c]});
            check("enables", c,
                  {28'd0, mxu_enable, mxu_enable_in_ff, mxu_enable_chain, mxu_enable_out_ff},
                  {28'd0, {4{e_en[c]}}});
            check("feed_zero", c, {31'd0, feed_zero}, {31'd0, e_fz[c]});
            if (c >= 1) begin
                check("data_type", c, {30'd0, mxu_data_type}, rst_seen ? 32'd0 : {30'd0, dt});
                check("fp_unit", c, {30'd0, mxu_enable_fp_unit}, rst_seen ? 32'd0 : {30'd0, fp});
            end
            if (in_valid && in_ready) nin++;
            if (out_valid && out_ready) nout++;
            if (rst_m[c]) rst_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        abort  = 1'b0;
        reset  = 1'b0;
        check("in_fires", ncyc, nin, e_nin);
        check("out_fires", ncyc, nout, e_nout);
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_len       = 16'd0;
        cfg_data_type = 2'b00;
        cfg_fp_unit   = 2'b00;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 0, {31'd0, busy}, 32'd0);
        check("rst_done", 0, {31'd0, done}, 32'd0);
        check("rst_in_ready", 0, {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", 0, {31'd0, out_valid}, 32'd0);
        check("rst_feed_zero", 0, {31'd0, feed_zero}, 32'd0);
        check("rst_enables", 0,
              {28'd0, mxu_enable, mxu_enable_in_ff, mxu_enable_chain, mxu_enable_out_ff}, 32'd0);
        check("rst_data_type", 0, {30'd0, mxu_data_type}, 32'd0);
        check("rst_fp_unit", 0, {30'd0, mxu_enable_fp_unit}, 32'd0);
        @(posedge clk);
        #1;

        // Basic job: inputs 1-4, DRAIN from 5, outputs 6-9, done 10, idle 11.
        run_job(16'd4, 2'b10, 2'b01, 12, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                32'h0000_07FE, 32'h0000_0400, 32'h0000_001E, 32'h0000_03C0,
                32'h0000_03FE, 32'h0000_03E0, 4, 4);

        // Backpressure 6-8 with start held high (ignored while busy): done 13.
        run_job(16'd4, 2'b01, 2'b10, 14, 1'b1,
                32'hFFFF_FFFF, 32'hFFFF_FE3F, 32'h0, 32'h0,
                32'h0000_3FFE, 32'h0000_2000, 32'h0000_001E, 32'h0000_1FC0,
                32'h0000_1E3E, 32'h0000_1E20, 4, 4);

        // Input gaps at 2-3 (array empty: frozen) and 8-9 (results pending: bubbles).
        run_job(16'd7, 2'b11, 2'b11, 19, 1'b0,
                32'hFFFF_FCF3, 32'hFFFF_FFFF, 32'h0, 32'h0,
                32'h0003_FFFE, 32'h0002_0000, 32'h0000_0FFE, 32'h0001_9F00,
                32'h0001_FFF2, 32'h0001_F300, 7, 7);

        // Zero-length job: done at cycle 1, no handshakes at all.
        run_job(16'd0, 2'b10, 2'b10, 3, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                32'h0000_0002, 32'h0000_0002, 32'h0, 32'h0,
                32'h0, 32'h0, 0, 0);

        // Abort at cycle 8 in DRAIN, sink stalled, two results still pending.
        run_job(16'd4, 2'b01, 2'b01, 12, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FEFF, 32'h0000_0100, 32'h0,
                32'h0000_01FE, 32'h0, 32'h0000_001E, 32'h0000_01C0,
                32'h0000_00FE, 32'h0000_00E0, 4, 2);

        // Fresh job after abort keeps cycle-0 timing.
        run_job(16'd4, 2'b10, 2'b01, 12, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                32'h0000_07FE, 32'h0000_0400, 32'h0000_001E, 32'h0000_03C0,
                32'h0000_03FE, 32'h0000_03E0, 4, 4);

        // Reset pulse at cycle 2 mid-STREAM: reset values from cycle 3.
        run_job(16'd4, 2'b11, 2'b10, 5, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0004,
                32'h0000_0006, 32'h0, 32'h0000_0006, 32'h0,
                32'h0000_0006, 32'h0, 2, 0);

        // Start accepted again after the reset.
        run_job(16'd4, 2'b01, 2'b11, 12, 1'b0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                32'h0000_07FE, 32'h0000_0400, 32'h0000_001E, 32'h0000_03C0,
                32'h0000_03FE, 32'h0000_03E0, 4, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mxu_sequencer.md
# mxu_sequencer

Control FSM that runs one matrix-multiply job on `mxu_wrapper`. It accepts a job (vector count, precision, FP-unit mode) and handshakes input vectors in from the feeder. It drives the wrapper's enable/stall signals so that the input skew registers, core and output deskew registers advance in lock-step. It tracks which outputs are valid and delivers them to the sink under ready/valid backpressure, signalling `done` when the last result has been accepted.

## Interface
- `M`, 3, MXU rows (weight/output lanes)
- `K`, 3, MXU columns (input lanes)
- `CORE_LAT`, 1, `mxu_core` input-to-output latency in enabled cycles
- `CNT_W`, 16, width of job length and counters
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high
- `start`  in  1  job request; sampled only in IDLE
- `abort`  in  1  cancel current job
- `cfg_len`  in  CNT_W  number of input vectors (= number of outputs)
- `cfg_data_type`  in  `LOG_ALLOWED_PRECISIONS`  precision for the job
- `cfg_fp_unit`  in  2  FP-unit enable for the job
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on job completion
- `in_valid` / `in_ready`  in / out  1  input vector handshake
- `feed_zero`  out  1  feeder must drive zero data this cycle (bubble/drain)
- `out_valid` / `out_ready`  out / in  1  result handshake (data is wrapper `y`)
- `mxu_data_type`  out  `LOG_ALLOWED_PRECISIONS`  registered copy of `cfg_data_type`
- `mxu_enable`, `mxu_enable_in_ff`, `mxu_enable_chain`, `mxu_enable_out_ff`  out  1 each  wrapper enables
- `mxu_enable_fp_unit`  out  2  registered copy of `cfg_fp_unit`

## Operation
- PIPE_LAT = (K-1) + CORE_LAT + (M-1).
- States: IDLE, STREAM, DRAIN, DONE.
  - IDLE: `start` → capture cfg into registers. Go to STREAM if `cfg_len`≠0, else DONE.
  - STREAM: exits to DRAIN on the in_fire where in_cnt == cfg_len-1.
  - DRAIN: exits to DONE on the out_fire where out_cnt == cfg_len-1.
  - DONE: `done`=1 for one cycle, then IDLE.
- Signal definitions:
  - stall = out_valid & ~out_ready.
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (STREAM) & ~stall.
  - bubble = DRAIN | (STREAM & ~in_valid & out_valid).
  - advance = ~stall & (in_fire | bubble).
  - feed_zero = advance & ~in_fire.
- All four `mxu_enable*` = advance. The whole array freezes on stall, so no result is lost.
- Valid tracking: PIPE_LAT-bit shift register, shifted on advance, head input = in_fire. out_valid = tail bit. Each shift retires the tail.
- Counters: in_cnt increments on in_fire and out_cnt on out_fire. Both clear in IDLE.
- `abort` in any non-IDLE state:
  - next state IDLE;
  - valid shift register and counters cleared;
  - `done` not pulsed.
  - `abort` in IDLE is ignored. `abort` has priority over `start` and over every transition.
- `start` outside IDLE is ignored. The cfg registers only change on an accepted `start`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `in_ready`, `out_valid`, `feed_zero`, all `mxu_enable*` = 0; `mxu_data_type` = 0; `mxu_enable_fp_unit` = 2'b00; shift register and counters 0.
- `start` accepted in cycle t:
  - `busy`=1 and `in_ready` possible from t+1.
  - `mxu_data_type`/`mxu_enable_fp_unit` valid from t+1 and held until the next accepted start.
- Latency: an input fired in cycle c appears as out_valid after exactly PIPE_LAT advancing cycles. With no stalls or gaps this is cycle c+PIPE_LAT.
- The `done` cycle is the cycle after the last out_fire. `busy` drops the cycle after `done`.
- All outputs are derived from registered state within the current cycle. There are no combinational paths from `in_valid` to `out_valid`.

## Structure
- Shared header `mxu_ctrl_def.vh`: state encodings, PIPE_LAT macro; reuses `LOG_ALLOWED_PRECISIONS` from `precision_def.vh`.
- One sub-module `valid_delay_line` (parameter DEPTH, inputs clk/reset/clear/shift/din, output dout), instantiated with DEPTH=PIPE_LAT.

## Test plan
All scenarios use M=K=3, CORE_LAT=1, PIPE_LAT=5.
- `start` at cycle 0 with cfg_len=4, in_valid and out_ready always high:
  - in_fire at cycles 1–4;
  - DRAIN from cycle 5;
  - out_valid at cycles 6–9;
  - `done` at cycle 10;
  - `busy` low at cycle 11.
- Backpressure: same job with out_ready low for cycles 6–8:
  - out_valid held high;
  - in_ready and all mxu enables 0 during those cycles;
  - 4 outputs delivered, none duplicated;
  - `done` at cycle 13.
- Input gaps: in_valid low for 2 cycles mid-STREAM:
  - enables low until out_valid exists, then bubbles with feed_zero=1;
  - exactly 4 outputs.
- cfg_len=0: `start` at cycle 0 gives `done` at cycle 1, never any in_ready or out_valid.
- `abort` in DRAIN with 2 results pending:
  - IDLE next cycle;
  - out_valid 0, no `done`;
  - a new job then runs cleanly from cycle-0 timing.
- `reset` asserted mid-STREAM for one cycle: all outputs at reset values on the following cycle, and `start` is accepted afterwards.
